// File: rtl/hazard_unit.sv
// Registered hazard controller for the X/W pipeline: load-use stalls, taken-redirect
// flushes and two-source operand forwarding, with state/counter exposed for debug.
module hazard_unit #(
    parameter int LOAD_LAT       = 1,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             x_valid,
    input  logic [6:0]       opcode_x,
    input  logic [4:0]       rs1_x,
    input  logic [4:0]       rs2_x,
    input  logic             branch_taken,
    input  logic             w_valid,
    input  logic [6:0]       opcode_w,
    input  logic [4:0]       rd_w,
    output logic             pc_hold,
    output logic             x_hold,
    output logic             w_hold,
    output logic             x_kill,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;

    localparam bit              HAS_LOAD_STALL = (LOAD_LAT > 0);
    localparam bit              HAS_BR_FLUSH   = (BRANCH_PENALTY > 1);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT > 0 ? LOAD_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] BR_CNT   = CNT_W'(BRANCH_PENALTY > 1 ? BRANCH_PENALTY - 2 : 0);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        BR_FLUSH  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic w_w_writes;
    logic w_w_load;
    logic w_x_reads1;
    logic w_x_reads2;
    logic w_match_a;
    logic w_match_b;
    logic w_load_use;
    logic w_redirect;

    // rd_w != 0 inside w_w_writes is what keeps x0 from ever matching.
    assign w_w_writes = w_valid && (rd_w != 5'd0) &&
                        (opcode_w == OPC_ARI_RTYPE || opcode_w == OPC_ARI_ITYPE ||
                         opcode_w == OPC_LOAD      || opcode_w == OPC_LUI       ||
                         opcode_w == OPC_AUIPC     || opcode_w == OPC_JAL       ||
                         opcode_w == OPC_JALR);
    assign w_w_load   = w_w_writes && (opcode_w == OPC_LOAD);
    assign w_x_reads1 = x_valid && !(opcode_x == OPC_LUI || opcode_x == OPC_AUIPC ||
                                     opcode_x == OPC_JAL);
    assign w_x_reads2 = x_valid && (opcode_x == OPC_ARI_RTYPE || opcode_x == OPC_STORE ||
                                    opcode_x == OPC_BRANCH);
    assign w_match_a  = w_x_reads1 && w_w_writes && (rs1_x == rd_w);
    assign w_match_b  = w_x_reads2 && w_w_writes && (rs2_x == rd_w);
    assign w_load_use = w_w_load && (w_match_a || w_match_b);
    assign w_redirect = x_valid && branch_taken;

    assign dbg_state = r_state;
    assign dbg_cnt   = r_cnt;

    function automatic logic [1:0] fwd_sel(input logic match, input logic is_load,
                                           input logic load_ok);
        if (!match)
            return 2'd0;
        else if (!is_load)
            return 2'd1;
        else
            return load_ok ? 2'd2 : 2'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // An external stall leaves state and count untouched.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (!stall) begin
            case (r_state)
                RUN: begin
                    if (w_load_use && HAS_LOAD_STALL) begin
                        w_state_next = LOAD_WAIT;
                        w_cnt_next   = LOAD_CNT;
                    end else if (w_redirect && HAS_BR_FLUSH) begin
                        w_state_next = BR_FLUSH;
                        w_cnt_next   = BR_CNT;
                    end
                end
                LOAD_WAIT: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else if (w_redirect && HAS_BR_FLUSH) begin
                        w_state_next = BR_FLUSH;
                        w_cnt_next   = BR_CNT;
                    end else begin
                        w_state_next = RUN;
                    end
                end
                BR_FLUSH: begin
                    if (r_cnt == '0)
                        w_state_next = RUN;
                    else
                        w_cnt_next = r_cnt - 1'b1;
                end
                default: begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_hold = 1'b0;
        x_hold  = 1'b0;
        w_hold  = 1'b0;
        x_kill  = 1'b0;
        fwd_a   = 2'd0;
        fwd_b   = 2'd0;
        if (rst) begin
            pc_hold = 1'b0;
        end else if (stall) begin
            pc_hold = 1'b1;
            x_hold  = 1'b1;
            w_hold  = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_load_use && HAS_LOAD_STALL) begin
                        pc_hold = 1'b1;
                        x_hold  = 1'b1;
                        w_hold  = 1'b1;
                    end else begin
                        // With no load latency the load data is usable right away.
                        fwd_a  = fwd_sel(w_match_a, w_w_load, !HAS_LOAD_STALL);
                        fwd_b  = fwd_sel(w_match_b, w_w_load, !HAS_LOAD_STALL);
                        x_kill = w_redirect;
                    end
                end
                LOAD_WAIT: begin
                    if (r_cnt != '0) begin
                        pc_hold = 1'b1;
                        x_hold  = 1'b1;
                        w_hold  = 1'b1;
                    end else begin
                        fwd_a  = fwd_sel(w_match_a, w_w_load, 1'b1);
                        fwd_b  = fwd_sel(w_match_b, w_w_load, 1'b1);
                        x_kill = w_redirect;
                    end
                end
                BR_FLUSH: x_kill = 1'b1;
                default:  x_kill = 1'b0;
            endcase
        end
    end

endmodule
